// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops 6-bit words from an upstream FIFO and sends each one as
// a UART-style frame on serial_o (start bit, data LSB first, optional even
// parity, stop bit). Every bit lasts CLKS_PER_BIT clk cycles.
//
// Build option: define FIFO_SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit. Left undefined, frames carry no
// parity bit and the parity state and logic are not built.
//
// State table
//   IDLE   | line high; pop a word when enabled and the FIFO has data
//   FETCH  | capture the popped word; clear the counters
//   START  | start bit (low) for one bit time
//   DATA   | DATA_W data bits, LSB first
//   PARITY | even parity of the captured word (only with the parity option)
//   STOP   | stop bit (high); frame_done on its final cycle
module fifo_serial_tx #(
  parameter int DATA_W       = 6,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_enable,
  output logic              serial_o,
  output logic              busy,
  output logic              frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
  // Cycle before the last one of a bit; frame_done is set up from here so it
  // arrives registered on the final stop-bit cycle.
  localparam logic [BAUD_W-1:0] BAUD_PRELAST = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST     = BIT_W'(DATA_W - 1);
  // With one clk per bit, the stop bit's first cycle is also its last.
  localparam bit                ONE_CLK      = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
`ifdef FIFO_SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [BIT_W-1:0]    r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_serial;
  logic                r_busy;
  logic                r_frame_done;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                r_parity;
`endif

  logic                w_pop;
  logic                w_baud_tc;
  logic [DATA_W-1:0]   w_shift_next;

  // Pop only from IDLE, so this block can never underflow the FIFO. The
  // reset term keeps the pop low while srst holds the FSM in IDLE.
  assign w_pop        = (r_state == S_IDLE) && enable && !fifo_empty && !srst;
  assign w_baud_tc    = (r_baud == BAUD_LAST);
  assign w_shift_next = r_shift >> 1;

  assign fifo_read_enable = w_pop;
  assign serial_o         = r_serial;
  assign busy             = r_busy;
  assign frame_done       = r_frame_done;

  // Frame sequencer; outputs are registered with the value of the next state.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_serial     <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_serial <= 1'b1;
          if (w_pop) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          r_shift  <= fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
          r_parity <= ^fifo_data;
`endif
          r_bit    <= '0;
          r_baud   <= '0;
          r_state  <= S_START;
          r_serial <= 1'b0;
        end

        S_START: begin
          if (w_baud_tc) begin
            r_baud   <= '0;
            r_state  <= S_DATA;
            r_serial <= r_shift[0];
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (w_baud_tc) begin
            r_baud  <= '0;
            r_shift <= w_shift_next;
            r_bit   <= r_bit + BIT_W'(1);
            if (r_bit == BIT_LAST) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
              r_state  <= S_PARITY;
              r_serial <= r_parity;
`else
              r_state      <= S_STOP;
              r_serial     <= 1'b1;
              r_frame_done <= ONE_CLK;
`endif
            end else begin
              r_serial <= w_shift_next[0];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end

`ifdef FIFO_SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_tc) begin
            r_baud       <= '0;
            r_state      <= S_STOP;
            r_serial     <= 1'b1;
            r_frame_done <= ONE_CLK;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
`endif

        S_STOP: begin
          r_serial <= 1'b1;
          if (w_baud_tc) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
            if (!ONE_CLK && (r_baud == BAUD_PRELAST)) begin
              r_frame_done <= 1'b1;
            end
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Testbench for fifo_serial_tx: a small FIFO model feeds the DUT, a scoreboard
// queue holds the words in push order, and each received frame is compared
// bit-cycle by bit-cycle against a frame built from the expected word.
module tb_fifo_serial_tx;

  localparam int DW  = 6;
  localparam int CPB = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int FL = (DW + 3) * CPB;
`else
  localparam int FL = (DW + 2) * CPB;
`endif

  logic          clk = 1'b0;
  logic          srst;
  logic          enable;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_read_enable;
  logic          serial_o;
  logic          busy;
  logic          frame_done;

  fifo_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk              (clk),
    .srst             (srst),
    .enable           (enable),
    .fifo_empty       (fifo_empty),
    .fifo_data        (fifo_data),
    .fifo_read_enable (fifo_read_enable),
    .serial_o         (serial_o),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: mem/wr_ptr written by the stimulus, rd_ptr by the read port.
  logic [DW-1:0] mem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic [DW-1:0] exp_q [$];

  // Read port: data valid the cycle after a pop, empty flag registered.
  always @(posedge clk) begin
    if (fifo_read_enable && (rd_ptr != wr_ptr)) begin
      fifo_data  <= mem[rd_ptr % 64];
      rd_ptr     <= rd_ptr + 1;
      fifo_empty <= ((rd_ptr + 1) == wr_ptr);
    end else begin
      fifo_empty <= (rd_ptr == wr_ptr);
    end
  end

  // Cycle counter and pop monitor.
  int   cyc = 0;
  int   n_pop_cycles = 0;
  int   n_pop_pulses = 0;
  int   last_pop_cyc = -100;
  logic prev_re = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_re <= fifo_read_enable;
    if (fifo_read_enable) begin
      n_pop_cycles <= n_pop_cycles + 1;
      last_pop_cyc <= cyc;
      if (!prev_re) n_pop_pulses <= n_pop_pulses + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  function automatic logic exp_level(input logic [DW-1:0] w, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
`ifdef FIFO_SERIAL_TX_PARITY_EN
    if (b == DW + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // Waits (bounded) for the start bit; returns at the negedge of its first cycle.
  task automatic wait_start(output int s);
    logic found;
    found = 1'b0;
    s = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (serial_o === 1'b0) begin
        found = 1'b1;
        s = cyc;
      end
    end
    chk("start_found", {31'd0, found}, 32'd1);
  endtask

  // Checks a whole frame from the start-bit cycle already sampled, then the
  // IDLE cycle that follows it.
  task automatic check_frame(input int s);
    logic [DW-1:0] w;
    logic line_ok, done_ok, busy_ok;
    w = '0;
    if (exp_q.size() != 0) w = exp_q.pop_front();
    chk("pop_to_start", s - last_pop_cyc, 32'd2);
    line_ok = 1'b1; done_ok = 1'b1; busy_ok = 1'b1;
    for (int k = 0; k < FL; k++) begin
      if (k > 0) @(negedge clk);
      if (serial_o !== exp_level(w, k)) line_ok = 1'b0;
      if (frame_done !== (k == FL - 1)) done_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk($sformatf("line_%02h", w), {31'd0, line_ok}, 32'd1);
    chk("frame_done_pos", {31'd0, done_ok}, 32'd1);
    chk("busy_in_frame", {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("line_idle_after", {31'd0, serial_o}, 32'd1);
  endtask

  initial begin
    int s1, s2, s3, p0, q0, bad_re, bad_ser, bad_busy;

    // Reset
    srst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_serial", {31'd0, serial_o}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_re", {31'd0, fifo_read_enable}, 32'd0);
    srst = 1'b0;

    // Enabled but FIFO empty for 100 cycles
    enable = 1'b1;
    bad_re = 0; bad_ser = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_read_enable !== 1'b0) bad_re++;
      if (serial_o !== 1'b1) bad_ser++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("empty_no_pop", bad_re, 32'd0);
    chk("empty_line_high", bad_ser, 32'd0);
    chk("empty_not_busy", bad_busy, 32'd0);

    // Single words
    push_word(6'b101101);
    wait_start(s1);
    check_frame(s1);
    push_word(6'b000111);
    wait_start(s1);
    check_frame(s1);
    chk("pops_single", n_pop_pulses, 32'd2);

    // Three words back to back
    p0 = n_pop_pulses; q0 = n_pop_cycles;
    push_word(6'h2A);
    push_word(6'h15);
    push_word(6'h3F);
    wait_start(s1);
    check_frame(s1);
    wait_start(s2);
    check_frame(s2);
    wait_start(s3);
    check_frame(s3);
    chk("gap_1_2", s2 - s1, FL + 2);
    chk("gap_2_3", s3 - s2, FL + 2);
    chk("b2b_pulses", n_pop_pulses - p0, 32'd3);
    chk("b2b_pop_cycles", n_pop_cycles - q0, 32'd3);

    // Reset in the middle of data bit 3: first word lost, second sent fresh
    push_word(6'h33);
    push_word(6'h0C);
    wait_start(s1);
    repeat (2 * CPB + 2 * CPB + 2) @(negedge clk);
    chk("pre_rst_bit3", {31'd0, serial_o}, 32'd0);
    #1 srst = 1'b1;
    #1;
    chk("async_rst_serial", {31'd0, serial_o}, 32'd1);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_re", {31'd0, fifo_read_enable}, 32'd0);
    @(negedge clk);
    srst = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    wait_start(s1);
    check_frame(s1);

    // Drop enable during the start bit: frame completes, no new pop
    push_word(6'h21);
    push_word(6'h1E);
    wait_start(s1);
    enable = 1'b0;
    check_frame(s1);
    q0 = n_pop_cycles;
    bad_ser = 0; bad_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (serial_o !== 1'b1) bad_ser++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("disabled_no_pop", n_pop_cycles - q0, 32'd0);
    chk("disabled_fifo_nonempty", {31'd0, fifo_empty}, 32'd0);
    chk("disabled_line_high", bad_ser, 32'd0);
    chk("disabled_not_busy", bad_busy, 32'd0);
    enable = 1'b1;
    wait_start(s1);
    check_frame(s1);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
